rxd_recv: RTL
=============

# rxd_recv

Serial receiver for the 32-bit word link driven by the board's UART-style transmitter. It oversamples the incoming `rxd` line at `clk` rate and recovers 8N1-style byte frames: start bit low, 8 data bits LSB first, at least one stop bit high. It assembles four bytes, most-significant byte first, into one 32-bit word and presents it with a single-cycle valid strobe. It sits at the FPGA pin side of the serial bus, opposite the transmitter, and feeds the command/data decoding logic.

## Interface
- `BAUD`, 434, clocks per bit period (50 MHz / baud rate); must be ≥ 4.
- `TIMEOUT`, 6944, idle clocks after which a partially assembled word is discarded (default 16 bit periods).
- `clk` input 1 system clock, 50 MHz.
- `rst_n` input 1 reset; one clock; reset is asynchronous and active-low.
- `rxd` input 1 serial line, asynchronous to `clk`, idle high.
- `data_out` output 32 last complete word; byte 0 received lands in [31:24], byte 3 in [7:0].
- `rxd_valid` output 1 one-cycle pulse when `data_out` has just been updated.
- `frame_err` output 1 one-cycle pulse on a bad stop bit.
- `rxd_busy` output 1 high while a frame is in progress or a partial word is held.

## Operation
- Input conditioning: `rxd` passes through 2 flops, `rxd_s`. Both flops reset to 1. All decisions use `rxd_s`.
- Bit-timer counter: sized for max(BAUD, TIMEOUT).
- IDLE:
  - A falling edge of `rxd_s` (previous 1, current 0) clears the bit timer and moves to START.
  - While in IDLE with byte_cnt ≠ 0, the idle counter increments.
  - When the idle counter reaches TIMEOUT, byte_cnt and the word shift register are cleared. No output pulse is produced.
- START: after BAUD/2 clocks (integer divide), sample `rxd_s`.
  - If 0, go to DATA with bit_cnt = 0.
  - If 1, treat as a glitch and return to IDLE. Partial word state is unchanged.
- DATA: every BAUD clocks, sample `rxd_s` into byte_sr[bit_cnt] (LSB first). After 8 samples, go to STOP.
- STOP: after BAUD clocks, sample `rxd_s`.
  - If 1: `word_sr <= {word_sr[23:0], byte_sr}`, then byte_cnt + 1. If byte_cnt was 3, then next cycle `data_out <= {word_sr[23:0], byte_sr}`, `rxd_valid` = 1, and byte_cnt = 0. Return to IDLE.
  - If 0: pulse `frame_err`, clear byte_cnt and word_sr, go to BREAK.
- BREAK: wait until `rxd_s` = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Idle counter: cleared on every start detection and whenever byte_cnt = 0.
- `rxd_busy` = (state ≠ IDLE) | (byte_cnt ≠ 0).
- Extra stop/idle bits between bytes are tolerated; any high time of at least one bit period is accepted.
- `data_out` holds its value until the next complete word.

## Timing
- Reset values: `data_out` = 0, `rxd_valid` = 0, `frame_err` = 0, `rxd_busy` = 0, state = IDLE, byte_cnt = 0. Asserting reset mid-frame aborts the frame and discards any partial word immediately.
- Let t0 be the cycle in which the falling edge is seen on `rxd_s`, which is 2 clocks after the pin edge.
- Sample points:
  - Start check at t0 + BAUD/2.
  - Data bit i at t0 + BAUD/2 + (i+1)·BAUD, for i = 0..7.
  - Stop bit at t0 + BAUD/2 + 9·BAUD.
- `rxd_valid` and `frame_err` assert the cycle after the stop sample and last exactly 1 cycle.
- Re-arm: the receiver is back in IDLE the cycle after the stop sample. A start edge arriving half a bit after the nominal stop centre is still caught.
- No back-pressure: a new word overwrites `data_out` and the consumer must capture on `rxd_valid`.

## Test plan
- BAUD=8, TIMEOUT=200. Send bytes A5, C3, 0F, 81, each with 2 leading idle bits and 4 stop bits. Expect `data_out` = 32'hA5C30F81, exactly one `rxd_valid` pulse, and `frame_err` never asserted.
- Send two back-to-back words 12345678 and DEADBEEF with a 1-bit gap. Expect two `rxd_valid` pulses, with `data_out` reading 12345678 then DEADBEEF.
- Send byte 55 with its stop bit driven 0. Expect one `frame_err` pulse and no `rxd_valid`. Then hold the line low 3 bit periods and release it: no further pulses. A following 4-byte word 01020304 is received correctly.
- Apply a 2-clock low glitch on an idle line. Expect no state change beyond START, `rxd_busy` falling back to 0, and no pulses.
- Send 2 bytes AA, BB, stay idle for more than 200 clocks, then send 11, 22, 33, 44. Expect a single `rxd_valid` with `data_out` = 32'h11223344.
- Assert `rst_n` low mid-way through byte 3 of a word, then release it and send CAFEF00D. Expect all outputs 0 during reset, then `data_out` = 32'hCAFEF00D with one `rxd_valid`.

Source files
------------

// File: rtl/rxd_recv.sv
// ============================================================================
// Module   : rxd_recv
// Purpose  : Oversampling 8N1 serial receiver assembling four bytes, MSB first,
//            into a 32-bit word with one-cycle valid and frame-error strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rxd_recv #(
    parameter int BAUD    = 434,
    parameter int TIMEOUT = 6944
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    output logic [31:0] data_out,
    output logic        rxd_valid,
    output logic        frame_err,
    output logic        rxd_busy
);

    localparam int c_CNT_MAX = (BAUD > TIMEOUT) ? BAUD : TIMEOUT;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(BAUD / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(BAUD - 1);
    localparam logic [c_CW-1:0] c_TOUT    = c_CW'(TIMEOUT);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_BREAK = 3'd4;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [c_CW-1:0] r_timer;
    logic [c_CW-1:0] r_idle_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_byte_sr;
    logic [31:0]     r_word_sr;
    logic [1:0]      r_byte_cnt;

    logic w_fall;
    logic w_tick_half;
    logic w_tick_bit;
    logic w_stop_ok;
    logic w_stop_bad;
    logic w_timeout;

    // Two-flop synchroniser; idle-high reset keeps reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall      = r_prev & ~r_sync2;
    assign w_tick_half = (r_timer == c_HALF_M1);
    assign w_tick_bit  = (r_timer == c_FULL_M1);
    assign w_timeout   = (r_idle_cnt == c_TOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_fall)      w_next = c_START;
            c_START: if (w_tick_half) w_next = r_sync2 ? c_IDLE : c_DATA;
            c_DATA:  if (w_tick_bit && (r_bit_cnt == 3'd7)) w_next = c_STOP;
            c_STOP:  if (w_tick_bit)  w_next = r_sync2 ? c_IDLE : c_BREAK;
            c_BREAK: if (r_sync2)     w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_stop_ok  = (r_state == c_STOP) && w_tick_bit && r_sync2;
        w_stop_bad = (r_state == c_STOP) && w_tick_bit && !r_sync2;
        rxd_busy   = (r_state != c_IDLE) || (r_byte_cnt != 2'd0);
    end

    // Timer restarts on every state change and at each data-bit sample point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if ((r_state == c_IDLE) || (r_state == c_BREAK) || (r_state != w_next) ||
                     ((r_state == c_DATA) && w_tick_bit)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 3'd0;
            r_byte_sr <= 8'd0;
        end else if (r_state == c_START) begin
            r_bit_cnt <= 3'd0;
        end else if ((r_state == c_DATA) && w_tick_bit) begin
            r_byte_sr[r_bit_cnt] <= r_sync2;
            r_bit_cnt            <= r_bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_byte_cnt == 2'd0) || ((r_state == c_IDLE) && w_fall)) begin
            r_idle_cnt <= '0;
        end else if ((r_state == c_IDLE) && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_sr  <= 32'd0;
            r_byte_cnt <= 2'd0;
            data_out   <= 32'd0;
            rxd_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (w_stop_ok) begin
                r_word_sr <= {r_word_sr[23:0], r_byte_sr};
                if (r_byte_cnt == 2'd3) begin
                    data_out   <= {r_word_sr[23:0], r_byte_sr};
                    rxd_valid  <= 1'b1;
                    r_byte_cnt <= 2'd0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
            end else if (w_stop_bad) begin
                frame_err  <= 1'b1;
                r_byte_cnt <= 2'd0;
                r_word_sr  <= 32'd0;
            end else if ((r_state == c_IDLE) && w_timeout) begin
                r_byte_cnt <= 2'd0;
                r_word_sr  <= 32'd0;
            end
        end
    end

endmodule

`default_nettype wire
